// File: rtl/datapath_controller.sv
// -----------------------------------------------------------------------------
// datapath_controller
//
// Moore FSM that sequences the register file and computation stage for one
// 16-bit instruction at a time. An instruction is latched into IR when s is
// seen in WAIT. The FSM then steps through decode, operand fetch, ALU and
// writeback, and returns to WAIT, where w=1 signals ready for the next one.
//
// Control outputs are registered. Their next value is decoded from the next
// state and the next IR, so each output always equals decode(state, IR) for
// the current cycle. sximm8 is combinational from IR.
//
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN
//   defined   : an illegal opcode sets a sticky err in DECODE. The FSM then
//               parks in WAIT with w=0 and ignores s until reset.
//   undefined : an illegal opcode is a 2-cycle NOP and err is tied 0.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   s, instr_in         start request and instruction (sampled in WAIT only)
//   w                   ready (high only in WAIT)
//   readnum, writenum   register-file read / write index
//   write, vsel         register-file write enable, writeback select
//   loada, loadb        A / B operand register loads
//   asel, bsel          ALU A-input / B-input selects
//   shift, ALUop        shifter and ALU operation
//   loadc, loads        C result and status register loads
//   sximm8              sign-extended IR[7:0]
//   err                 illegal-opcode indication
// -----------------------------------------------------------------------------
module datapath_controller #(
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s,
  input  logic [15:0]           instr_in,
  output logic                  w,
  output logic [REG_ADDR_W-1:0] readnum,
  output logic [REG_ADDR_W-1:0] writenum,
  output logic                  write,
  output logic [1:0]            vsel,
  output logic                  loada,
  output logic                  loadb,
  output logic                  asel,
  output logic                  bsel,
  output logic [1:0]            shift,
  output logic [1:0]            ALUop,
  output logic                  loadc,
  output logic                  loads,
  output logic [15:0]           sximm8,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_ALU, S_WR_REG, S_WR_IMM
  } state_t;

  typedef struct packed {
    logic                  w;
    logic [REG_ADDR_W-1:0] readnum;
    logic [REG_ADDR_W-1:0] writenum;
    logic                  write;
    logic [1:0]            vsel;
    logic                  loada;
    logic                  loadb;
    logic                  asel;
    logic                  bsel;
    logic [1:0]            shift;
    logic [1:0]            aluop;
    logic                  loadc;
    logic                  loads;
  } ctrl_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        err_q, err_d;
  ctrl_t       ctrl_q, ctrl_d;

  // Instruction class helpers (opcode = ir[15:13], op = ir[12:11]).
  function automatic logic is_mov_imm(input logic [15:0] ir);
    return (ir[15:13] == 3'b110) && (ir[12:11] == 2'b10);
  endfunction

  function automatic logic is_mov_reg(input logic [15:0] ir);
    return (ir[15:13] == 3'b110) && (ir[12:11] == 2'b00);
  endfunction

  function automatic logic is_alu(input logic [15:0] ir);
    return ir[15:13] == 3'b101;
  endfunction

  // Moore output decode: depends only on state, IR and the sticky err flag.
  function automatic ctrl_t decode_ctrl(input state_t st, input logic [15:0] ir,
                                        input logic err_f);
    ctrl_t c;
    logic  unary;
    c     = '0;
    // MOV reg and MVN use only the B operand, so A is forced to zero.
    unary = is_mov_reg(ir) || (is_alu(ir) && (ir[12:11] == 2'b11));
    case (st)
      S_WAIT:   c.w = !err_f;
      S_GET_A: begin
        c.readnum = ir[10:8];
        c.loada   = 1'b1;
      end
      S_GET_B: begin
        c.readnum = ir[2:0];
        c.loadb   = 1'b1;
      end
      S_ALU: begin
        c.shift = ir[4:3];
        c.asel  = !unary;
        c.aluop = is_mov_reg(ir) ? 2'b00 : ir[12:11];
        if (is_alu(ir) && (ir[12:11] == 2'b01)) c.loads = 1'b1;
        else                                    c.loadc = 1'b1;
      end
      S_WR_REG: begin
        c.writenum = ir[7:5];
        c.vsel     = 2'b00;
        c.write    = 1'b1;
      end
      S_WR_IMM: begin
        c.writenum = ir[10:8];
        c.vsel     = 2'b01;
        c.write    = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    err_d   = err_q;
    case (state_q)
      S_WAIT: begin
        if (s && !err_q) begin
          ir_d    = instr_in;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_mov_imm(ir_q))
          state_d = S_WR_IMM;
        else if (is_mov_reg(ir_q) || (is_alu(ir_q) && (ir_q[12:11] == 2'b11)))
          state_d = S_GET_B;
        else if (is_alu(ir_q))
          state_d = S_GET_A;
        else begin
          state_d = S_WAIT;
`ifdef CTRL_ILLEGAL_TRAP_EN
          err_d   = 1'b1;
`endif
        end
      end
      S_GET_A:  state_d = S_GET_B;
      S_GET_B:  state_d = S_ALU;
      S_ALU:    state_d = (is_alu(ir_q) && (ir_q[12:11] == 2'b01)) ? S_WAIT : S_WR_REG;
      S_WR_REG: state_d = S_WAIT;
      S_WR_IMM: state_d = S_WAIT;
      default:  state_d = S_WAIT;
    endcase
`ifndef CTRL_ILLEGAL_TRAP_EN
    err_d = 1'b0;
`endif
    ctrl_d = decode_ctrl(state_d, ir_d, err_d);
  end

  // Reset aborts any instruction in flight: outputs drop to the WAIT pattern.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_WAIT;
      ir_q     <= '0;
      err_q    <= 1'b0;
      ctrl_q   <= '0;
      ctrl_q.w <= 1'b1;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign w        = ctrl_q.w;
  assign readnum  = ctrl_q.readnum;
  assign writenum = ctrl_q.writenum;
  assign write    = ctrl_q.write;
  assign vsel     = ctrl_q.vsel;
  assign loada    = ctrl_q.loada;
  assign loadb    = ctrl_q.loadb;
  assign asel     = ctrl_q.asel;
  assign bsel     = ctrl_q.bsel;
  assign shift    = ctrl_q.shift;
  assign ALUop    = ctrl_q.aluop;
  assign loadc    = ctrl_q.loadc;
  assign loads    = ctrl_q.loads;
  assign sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};
  assign err      = err_q;

endmodule

// File: tb/tb_datapath_controller.sv
// Directed bench for datapath_controller. Inputs change 1 time unit after a
// rising edge and outputs are sampled at the same point. Step k after the
// accept edge therefore shows the state entered on edge k.
module tb_datapath_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s;
  logic [15:0] instr_in;
  logic        w, write, loada, loadb, asel, bsel, loadc, loads, err;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8;

  int n_cmp = 0;
  int n_mis = 0;

  datapath_controller #(.REG_ADDR_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .s(s), .instr_in(instr_in),
    .w(w), .readnum(readnum), .writenum(writenum), .write(write),
    .vsel(vsel), .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
    .shift(shift), .ALUop(ALUop), .loadc(loadc), .loads(loads),
    .sximm8(sximm8), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction with s=1 and take the accept edge (edge 1).
  task automatic issue(input logic [15:0] instr);
    s        = 1'b1;
    instr_in = instr;
    step();
    s        = 1'b0;
    instr_in = 16'hFFFF;   // junk: must be ignored outside WAIT
  endtask

  int first_wr, second_wr, n_wr;
  logic [15:0] wr_imm;
  logic        saw_write;

  initial begin
    reset_n  = 1'b0;
    s        = 1'b0;
    instr_in = 16'h0000;
    step();
    step();
    check("rst_w",      16'(w),       16'h0001);
    check("rst_write",  16'(write),   16'h0000);
    check("rst_err",    16'(err),     16'h0000);
    check("rst_sximm8", sximm8,       16'h0000);
    check("rst_loada",  16'(loada),   16'h0000);
    reset_n = 1'b1;
    step();
    check("idle_w",     16'(w),       16'h0001);

    // MOV R1,#7
    issue(16'hD107);
    check("movi_e1_w",  16'(w),        16'h0000);
    step();
    check("movi_write", 16'(write),    16'h0001);
    check("movi_wnum",  16'(writenum), 16'h0001);
    check("movi_vsel",  16'(vsel),     16'h0001);
    check("movi_sx",    sximm8,        16'h0007);
    step();
    check("movi_e3_w",  16'(w),        16'h0001);
    check("movi_e3_wr", 16'(write),    16'h0000);

    // ADD R2,R1,R0
    issue(16'hA140);
    step();
    check("add_ga_rn",  16'(readnum),  16'h0001);
    check("add_ga_lda", 16'(loada),    16'h0001);
    step();
    check("add_gb_rm",  16'(readnum),  16'h0000);
    check("add_gb_ldb", 16'(loadb),    16'h0001);
    step();
    check("add_alu_as", 16'(asel),     16'h0001);
    check("add_alu_op", 16'(ALUop),    16'h0000);
    check("add_alu_lc", 16'(loadc),    16'h0001);
    check("add_alu_ls", 16'(loads),    16'h0000);
    check("add_alu_bs", 16'(bsel),     16'h0000);
    step();
    check("add_wr_num", 16'(writenum), 16'h0002);
    check("add_wr_en",  16'(write),    16'h0001);
    check("add_wr_vs",  16'(vsel),     16'h0000);
    check("add_e5_w",   16'(w),        16'h0000);
    step();
    check("add_e6_w",   16'(w),        16'h0001);

    // CMP R1,R0 LSL1
    saw_write = 1'b0;
    issue(16'hA908);
    saw_write |= write;
    step();
    saw_write |= write;
    check("cmp_ga_rn",  16'(readnum),  16'h0001);
    step();
    saw_write |= write;
    step();
    saw_write |= write;
    check("cmp_alu_sh", 16'(shift),    16'h0001);
    check("cmp_alu_op", 16'(ALUop),    16'h0001);
    check("cmp_alu_ls", 16'(loads),    16'h0001);
    check("cmp_alu_lc", 16'(loadc),    16'h0000);
    check("cmp_alu_as", 16'(asel),     16'h0001);
    step();
    check("cmp_e5_w",   16'(w),        16'h0001);
    check("cmp_nowrite",16'(saw_write),16'h0000);

    // MVN R3,R1
    issue(16'hB861);
    step();
    check("mvn_gb_rm",  16'(readnum),  16'h0001);
    check("mvn_gb_ldb", 16'(loadb),    16'h0001);
    check("mvn_gb_lda", 16'(loada),    16'h0000);
    step();
    check("mvn_alu_as", 16'(asel),     16'h0000);
    check("mvn_alu_op", 16'(ALUop),    16'h0003);
    check("mvn_alu_lc", 16'(loadc),    16'h0001);
    step();
    check("mvn_wr_num", 16'(writenum), 16'h0003);
    check("mvn_wr_en",  16'(write),    16'h0001);
    step();
    check("mvn_e5_w",   16'(w),        16'h0001);

    // MOV R2,R5 LSR1 (110/00): ALUop forced to 00, A zeroed
    issue(16'hC555);
    step();
    check("movr_gb_rm", 16'(readnum),  16'h0005);
    step();
    check("movr_alu_op",16'(ALUop),    16'h0000);
    check("movr_alu_as",16'(asel),     16'h0000);
    check("movr_alu_sh",16'(shift),    16'h0002);
    step();
    check("movr_wr_num",16'(writenum), 16'h0002);
    step();
    check("movr_e5_w",  16'(w),        16'h0001);

    // Reset in the middle of an ADD, during ALU
    issue(16'hA140);
    step();
    step();
    step();
    check("mid_alu_lc", 16'(loadc),    16'h0001);
    reset_n = 1'b0;
    #1;
    check("mid_rst_w",  16'(w),        16'h0001);
    check("mid_rst_lc", 16'(loadc),    16'h0000);
    check("mid_rst_sx", sximm8,        16'h0000);
    step();
    check("mid_rst_wr", 16'(write),    16'h0000);
    check("mid_rst_w2", 16'(w),        16'h0001);
    reset_n = 1'b1;
    step();
    check("post_rst_w", 16'(w),        16'h0001);

`ifdef CTRL_ILLEGAL_TRAP_EN
    // Illegal opcode traps: err sticky, w held low despite s
    s        = 1'b1;
    instr_in = 16'hE000;
    step();
    step();
    check("ill_err",    16'(err),      16'h0001);
    check("ill_w",      16'(w),        16'h0000);
    step();
    step();
    check("ill_w_held", 16'(w),        16'h0000);
    check("ill_err_hd", 16'(err),      16'h0001);
    s       = 1'b0;
    reset_n = 1'b0;
    step();
    check("ill_rst_err",16'(err),      16'h0000);
    reset_n = 1'b1;
    step();
    check("ill_rst_w",  16'(w),        16'h0001);
`else
    // Illegal opcode is a 2-edge NOP
    issue(16'hE000);
    check("ill_e1_w",   16'(w),        16'h0000);
    step();
    check("ill_e2_w",   16'(w),        16'h0001);
    check("ill_err",    16'(err),      16'h0000);
    check("ill_write",  16'(write),    16'h0000);
`endif

    // Back-to-back MOV R1,#-1 with s held
    first_wr  = -1;
    second_wr = -1;
    n_wr      = 0;
    wr_imm    = 16'h0000;
    s         = 1'b1;
    instr_in  = 16'hD1FF;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 4) s = 1'b0;
      if (write) begin
        n_wr++;
        wr_imm = sximm8;
        if (first_wr < 0) first_wr = e;
        else if (second_wr < 0) second_wr = e;
      end
    end
    check("b2b_nwr",    16'(n_wr),               16'h0002);
    check("b2b_first",  16'(first_wr),           16'h0002);
    check("b2b_gap",    16'(second_wr - first_wr), 16'h0003);
    check("b2b_sx",     wr_imm,                  16'hFFFF);
    check("b2b_end_w",  16'(w),                  16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
